// File: rtl/lia_ref_gen.sv
// lia_ref_gen: quadrature sine/cosine reference for the lock-in amplifier.
// A 32-bit phase accumulator and a quarter-wave table produce
// sin(theta) and cos(theta) as 14-bit signed samples, plus a wrap pulse.
//
// Ports (single clock domain, dac_clk_i, 125 MHz):
//   dac_clk_i    clock
//   dac_rstn_i   synchronous active-low reset
//   ftw_i        frequency tuning word, f = ftw * fclk / 2^PHASE_W
//   pha_off_i    phase offset added after the accumulator
//   cfg_we_i     strobe latching ftw_i and pha_off_i
//   run_i        1 advances the accumulator, 0 holds it
//   sync_i       clears the accumulator (wins over run_i)
//   in_phase_o   sin(theta), two's complement, -8191..+8191
//   out_phase_o  sin(theta + 90 deg)
//   valid_o      high once the pipeline has filled after reset
//   ref_sync_o   one-cycle pulse, in-phase quadrant 3 -> 0, output-aligned
//
// Build option: define LIA_REF_DITHER_EN to add LFSR phase dither
// below the table address bits (spreads truncation spurs).
// Latency: outputs at edge n+3 reflect acc/off_r after edge n.
module lia_ref_gen #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 14
) (
    input  logic                    dac_clk_i,
    input  logic                    dac_rstn_i,
    input  logic [PHASE_W-1:0]      ftw_i,
    input  logic [PHASE_W-1:0]      pha_off_i,
    input  logic                    cfg_we_i,
    input  logic                    run_i,
    input  logic                    sync_i,
    output logic signed [OUT_W-1:0] in_phase_o,
    output logic signed [OUT_W-1:0] out_phase_o,
    output logic                    valid_o,
    output logic                    ref_sync_o
);

    localparam int  MAG_W  = OUT_W - 1;
    localparam int  LUT_N  = 1 << LUT_AW;
    localparam int  TOP_W  = LUT_AW + 2;
    localparam real TWO_PI = 6.283185307179586;
    localparam real FULL   = real'((1 << MAG_W) - 1);

    // One table lookup: effective address plus sign to apply.
    typedef struct packed {
        logic [LUT_AW-1:0] addr;
        logic              neg;
    } tap_t;

    // One table sample travelling to the sign stage.
    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             neg;
    } smp_t;

    // Quarter-wave table, half-LSB phase offset so that
    // no entry is 0 and the full wave is symmetric.
    logic [MAG_W-1:0] lut [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = MAG_W'($rtoi(
            FULL * $sin(TWO_PI * (real'(k) + 0.5)
                        / real'(4 * LUT_N)) + 0.5));
    end

    // ------------------------------------------------------------
    // Stage 0: configuration and accumulator
    // ------------------------------------------------------------
    logic [PHASE_W-1:0] ftw_r;
    logic [PHASE_W-1:0] off_r;
    logic [PHASE_W-1:0] acc;

    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            ftw_r <= '0;
            off_r <= '0;
        end else if (cfg_we_i) begin
            ftw_r <= ftw_i;
            off_r <= pha_off_i;
        end
    end

    // acc uses the ftw_r value held before a same-cycle cfg write.
    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            acc <= '0;
        end else if (sync_i) begin
            acc <= '0;
        end else if (run_i) begin
            acc <= acc + ftw_r;
        end
    end

    // ------------------------------------------------------------
    // Phase computation (optionally dithered)
    // ------------------------------------------------------------
    logic [PHASE_W-1:0] theta_i;

`ifdef LIA_REF_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        theta_i = acc + off_r + PHASE_W'({lfsr, 6'b0});
    end
`else
    always_comb begin
        theta_i = acc + off_r;
    end
`endif

    // Only the quadrant and table address survive truncation.
    // The Q path adds 90 deg, i.e. +1 in the quadrant field,
    // which is exact and shares the (dithered) I address bits.
    logic [TOP_W-1:0] top_i;
    logic [1:0]       quad_i;
    logic [1:0]       quad_q;
    logic             unused_lsb;

    assign top_i      = theta_i[PHASE_W-1 -: TOP_W];
    assign unused_lsb = ^theta_i[PHASE_W-TOP_W-1:0];
    assign quad_i     = top_i[TOP_W-1 -: 2];
    assign quad_q     = quad_i + 2'd1;

    // Odd quadrants run the quarter table backwards,
    // the second half of the wave is negated.
    function automatic tap_t make_tap(
        input logic [1:0]        q,
        input logic [LUT_AW-1:0] a
    );
        tap_t t;
        t.addr = q[0] ? ~a : a;
        t.neg  = q[1];
        return t;
    endfunction

    // ------------------------------------------------------------
    // Stage 1: quadrant and effective address
    // ------------------------------------------------------------
    tap_t       s1_i;
    tap_t       s1_q;
    logic [1:0] s1_quad;
    logic [1:0] s1_quad_prev;

    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            s1_i         <= '0;
            s1_q         <= '0;
            s1_quad      <= '0;
            s1_quad_prev <= '0;
        end else begin
            s1_i         <= make_tap(quad_i, top_i[LUT_AW-1:0]);
            s1_q         <= make_tap(quad_q, top_i[LUT_AW-1:0]);
            s1_quad      <= quad_i;
            s1_quad_prev <= s1_quad;
        end
    end

    logic wrap1;

    assign wrap1 = (s1_quad == 2'd0) && (s1_quad_prev == 2'd3);

    // ------------------------------------------------------------
    // Stage 2: table read (two ports on one table)
    // ------------------------------------------------------------
    smp_t s2_i;
    smp_t s2_q;
    logic s2_wrap;

    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            s2_i    <= '0;
            s2_q    <= '0;
            s2_wrap <= 1'b0;
        end else begin
            s2_i.mag <= lut[s1_i.addr];
            s2_i.neg <= s1_i.neg;
            s2_q.mag <= lut[s1_q.addr];
            s2_q.neg <= s1_q.neg;
            s2_wrap  <= wrap1;
        end
    end

    // ------------------------------------------------------------
    // Fill tracking: stage 2 holds real data once v2 is set,
    // so stage 3 stays at 0 until then.
    // ------------------------------------------------------------
    logic v1;
    logic v2;

    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            v1      <= 1'b1;
            v2      <= v1;
            valid_o <= v2;
        end
    end

    // ------------------------------------------------------------
    // Stage 3: sign and output registers
    // ------------------------------------------------------------
    function automatic logic signed [OUT_W-1:0] apply_sign(
        input smp_t s
    );
        logic signed [OUT_W-1:0] m;
        m = $signed({1'b0, s.mag});
        return s.neg ? -m : m;
    endfunction

    always_ff @(posedge dac_clk_i) begin
        if (!dac_rstn_i) begin
            in_phase_o  <= '0;
            out_phase_o <= '0;
            ref_sync_o  <= 1'b0;
        end else if (v2) begin
            in_phase_o  <= apply_sign(s2_i);
            out_phase_o <= apply_sign(s2_q);
            ref_sync_o  <= s2_wrap;
        end else begin
            in_phase_o  <= '0;
            out_phase_o <= '0;
            ref_sync_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lia_ref_gen.sv
// tb_lia_ref_gen: self-checking bench for lia_ref_gen.
// Table vectors, hand sequences and random stimulus vs a sine model.
module tb_lia_ref_gen;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic               rstn;
    logic [31:0]        ftw;
    logic [31:0]        off;
    logic               we;
    logic               run;
    logic               sync;
    logic signed [13:0] in_ph;
    logic signed [13:0] out_ph;
    logic               valid;
    logic               rsync;

    lia_ref_gen dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rstn),
        .ftw_i       (ftw),
        .pha_off_i   (off),
        .cfg_we_i    (we),
        .run_i       (run),
        .sync_i      (sync),
        .in_phase_o  (in_ph),
        .out_phase_o (out_ph),
        .valid_o     (valid),
        .ref_sync_o  (rsync)
    );

    int checks = 0;
    int errors = 0;
    string tag = "reset";

    // Behavioural model state.
    logic [31:0] m_ftw;
    logic [31:0] m_off;
    logic [31:0] m_acc;
    int          m_cnt;
    logic [31:0] th_q[$];
    int          e_i;
    int          e_q;
    int          e_v;
    int          e_s;

    // Full-wave sine sampled at the centre of each 1024-step bin.
    function automatic int ref_sin(input logic [31:0] th);
        real s;
        s = 8191.0 * $sin(2.0 * 3.141592653589793
                          * (real'(th[31:22]) + 0.5) / 1024.0);
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d",
                     tag, name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] old_ftw;
        logic [31:0] th3;
        logic [31:0] th4;
        if (!rstn) begin
            m_ftw = '0;
            m_off = '0;
            m_acc = '0;
            m_cnt = 0;
        end else begin
            old_ftw = m_ftw;
            if (we) begin
                m_ftw = ftw;
                m_off = off;
            end
            if (sync)     m_acc = '0;
            else if (run) m_acc = m_acc + old_ftw;
            if (m_cnt < 100) m_cnt++;
        end
        th_q.push_back(m_acc + m_off);
        if (th_q.size() > 8) void'(th_q.pop_front());
        if (m_cnt >= 3) begin
            th3 = th_q[th_q.size()-4];
            th4 = th_q[th_q.size()-5];
            e_i = ref_sin(th3);
            e_q = ref_sin(th3 + 32'h4000_0000);
            e_v = 1;
            e_s = (th3[31:30] == 2'd0 && m_cnt >= 4
                   && th4[31:30] == 2'd3) ? 1 : 0;
        end else begin
            e_i = 0;
            e_q = 0;
            e_v = 0;
            e_s = 0;
        end
    endtask

    // One clock: inputs already driven, model follows the edge,
    // outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("in_phase",  in_ph,  e_i);
        check("out_phase", out_ph, e_q);
        check("valid",     valid,  e_v);
        check("ref_sync",  rsync,  e_s);
    endtask

    typedef struct {
        logic [31:0] off;
        int          exp_i;
        int          exp_q;
    } vec_t;

    vec_t vecs[8];

    int pat_i[4];
    int pat_q[4];

    initial begin
        vecs[0] = '{32'h0000_0000,    25,  8191};
        vecs[1] = '{32'h4000_0000,  8191,   -25};
        vecs[2] = '{32'h8000_0000,   -25, -8191};
        vecs[3] = '{32'hC000_0000, -8191,    25};
        vecs[4] = '{32'h3FC0_0000,  8191,    25};
        vecs[5] = '{32'h0040_0000,    75,  8191};
        vecs[6] = '{32'hFFFF_FFFF,   -25,  8191};
        vecs[7] = '{32'h7FFF_FFFF,    25, -8191};
        pat_i = '{25, 8191, -25, -8191};
        pat_q = '{8191, -25, -8191, 25};

        for (int i = 0; i < 8; i++) th_q.push_back('0);
        m_ftw = '0; m_off = '0; m_acc = '0; m_cnt = 0;
        rstn = 1'b0; we = 1'b0; run = 1'b0; sync = 1'b0;
        ftw = '0; off = '0;

        // Reset and fill.
        for (int i = 0; i < 5; i++) tick();
        rstn = 1'b1;
        tick();
        check("fill1_valid", valid, 0);
        check("fill1_in", in_ph, 0);
        tick();
        check("fill2_valid", valid, 0);
        tick();
        check("fill3_valid", valid, 1);
        check("fill3_in", in_ph, 25);

        // Quarter-rate sine.
        tag = "quarter";
        ftw = 32'h4000_0000; off = '0;
        we = 1'b1; sync = 1'b1; run = 1'b1;
        tick();
        we = 1'b0; sync = 1'b0;
        tick();
        tick();
        for (int j = 0; j < 12; j++) begin
            tick();
            check("q_in",  in_ph,  pat_i[j % 4]);
            check("q_out", out_ph, pat_q[j % 4]);
            check("q_sync", rsync, (j % 4 == 0 && j > 0) ? 1 : 0);
        end

        // Hold, then sync.
        tag = "hold";
        run = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        run = 1'b1; sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        tick();
        tick();
        check("sync_in", in_ph, 25);

        // Static offsets.
        tag = "static";
        for (int v = 0; v < 8; v++) begin
            ftw = '0; off = vecs[v].off;
            we = 1'b1; sync = 1'b1; run = 1'b1;
            tick();
            we = 1'b0; sync = 1'b0;
            for (int j = 0; j < 4; j++) tick();
            check("vec_in",  in_ph,  vecs[v].exp_i);
            check("vec_out", out_ph, vecs[v].exp_q);
        end

        // Live retune.
        tag = "retune";
        ftw = 32'h4000_0000; off = '0;
        we = 1'b1; sync = 1'b1; run = 1'b1;
        tick();
        we = 1'b0; sync = 1'b0;
        tick();
        ftw = 32'h8000_0000; we = 1'b1;
        tick();
        we = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        for (int j = 0; j < 6; j++) begin
            tick();
            check("rt_in", in_ph, (j % 2 == 0) ? 25 : -25);
        end

        // Random traffic including occasional reset.
        tag = "random";
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 199) != 0);
            we   = ($urandom_range(0, 7) == 0);
            sync = ($urandom_range(0, 15) == 0);
            run  = ($urandom_range(0, 3) != 0);
            ftw  = $urandom;
            off  = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
